// File: rtl/mc_ctrl.sv
// Multi-cycle fetch/decode/execute control FSM with bounded memory waits.
// Optional performance counters are enabled by defining MC_CTRL_PERF_EN.
module mc_ctrl #(
    parameter int WAIT_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        im_ready,
    input  logic        dm_ready,
    output logic        IRWr,
    output logic        PCWr,
    output logic [1:0]  NPCOp,
    output logic [2:0]  ALUOp,
    output logic        DMWr,
    output logic        RFWr,
    output logic        illegal,
    output logic        timeout,
    output logic [2:0]  state
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXE    = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] wait_cnt, wait_d;

    logic is_r, is_lw, is_sw, is_beq, is_j, is_addiu, is_ori, is_lui, legal;
    logic [2:0] alu_sel;
    logic waiting, at_limit, wait_expired;
    logic irwr_c, pcwr_c, dmwr_c, rfwr_c, illegal_c;
    logic [1:0] npcop_c;
    logic [2:0] aluop_c;

    assign is_lw    = (opcode == 6'h23);
    assign is_sw    = (opcode == 6'h2B);
    assign is_beq   = (opcode == 6'h04);
    assign is_j     = (opcode == 6'h02);
    assign is_addiu = (opcode == 6'h09);
    assign is_ori   = (opcode == 6'h0D);
    assign is_lui   = (opcode == 6'h0F);
    assign is_r     = (opcode == 6'h00) &&
                      (funct == 6'h21 || funct == 6'h23 || funct == 6'h24 ||
                       funct == 6'h25 || funct == 6'h2A);
    assign legal    = is_r | is_lw | is_sw | is_beq | is_j | is_addiu | is_ori | is_lui;

    always_comb begin
        alu_sel = 3'b000;
        if (is_beq) alu_sel = 3'b001;
        else if (is_ori) alu_sel = 3'b011;
        else if (is_lui) alu_sel = 3'b101;
        else if (is_r) begin
            case (funct)
                6'h23:   alu_sel = 3'b001;
                6'h24:   alu_sel = 3'b010;
                6'h25:   alu_sel = 3'b011;
                6'h2A:   alu_sel = 3'b100;
                default: alu_sel = 3'b000;
            endcase
        end
    end

    // A ready in the same cycle as the limit wins: waiting is false then.
    assign waiting      = (state_q == S_FETCH && !im_ready) || (state_q == S_MEM && !dm_ready);
    assign at_limit     = (wait_cnt == CW'(WAIT_LIMIT - 1));
    assign wait_expired = waiting && at_limit;
    assign wait_d       = (waiting && !at_limit) ? wait_cnt + 1'b1 : '0;

    always_comb begin
        state_d   = S_FETCH;
        irwr_c    = 1'b0;
        pcwr_c    = 1'b0;
        npcop_c   = 2'b00;
        aluop_c   = 3'b000;
        dmwr_c    = 1'b0;
        rfwr_c    = 1'b0;
        illegal_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (im_ready) begin
                    irwr_c  = 1'b1;
                    pcwr_c  = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (is_j) begin
                    pcwr_c  = 1'b1;
                    npcop_c = 2'b10;
                    state_d = S_FETCH;
                end else if (!legal) begin
                    illegal_c = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                aluop_c = alu_sel;
                if (is_beq) begin
                    pcwr_c  = zero;
                    npcop_c = 2'b01;
                    state_d = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                aluop_c = alu_sel;
                if (dm_ready) begin
                    dmwr_c  = is_sw;
                    state_d = is_sw ? S_FETCH : S_WB;
                end else if (at_limit) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                aluop_c = alu_sel;
                rfwr_c  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_d;
        end
    end

    // Strobes are forced low during reset since they decode live inputs.
    assign IRWr    = irwr_c & ~rst;
    assign PCWr    = pcwr_c & ~rst;
    assign NPCOp   = rst ? 2'b00 : npcop_c;
    assign ALUOp   = rst ? 3'b000 : aluop_c;
    assign DMWr    = dmwr_c & ~rst;
    assign RFWr    = rfwr_c & ~rst;
    assign illegal = illegal_c & ~rst;
    assign timeout = wait_expired & ~rst;
    assign state   = state_q;

`ifdef MC_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (state_q == S_FETCH && state_d == S_DECODE)
                instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule
